// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the MAR/MDR memory protocol.
// Holds MAR, MDR and a single-port 32-bit RAM. A Read or Write request is
// accepted in IDLE or DONE, waits WAIT_STATES extra cycles in WAIT, performs
// the access on the next edge and reports completion with a one-cycle pulse.
//
// Ports:
//   clock        system clock, rising-edge active
//   reset        synchronous active-high reset (RAM contents are kept)
//   BusMuxOut    shared bus value (MAR / MDR load source)
//   MARin        load MAR from BusMuxOut[ADDR_BITS-1:0]
//   MDRin        load MDR; bus load only when MD_read = 0
//   MD_read      1: suppress the MDR bus load (memory is the MDR source)
//   Read, Write  access requests (Read wins when both are high)
//   MDR_bus      current MDR value
//   MAR_out      current MAR value
//   busy         request in progress (state WAIT)
//   mem_done     one-cycle completion pulse (state DONE)
//   req_dropped  sticky flag: a request was ignored
module mem_responder #(
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          BusMuxOut,
  input  logic                 MARin,
  input  logic                 MDRin,
  input  logic                 MD_read,
  input  logic                 Read,
  input  logic                 Write,
  output logic [31:0]          MDR_bus,
  output logic [ADDR_BITS-1:0] MAR_out,
  output logic                 busy,
  output logic                 mem_done,
  output logic                 req_dropped
);

  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [1:0]           state_q,   state_d;
  logic [3:0]           cnt_q,     cnt_d;
  logic [ADDR_BITS-1:0] addr_q,    addr_d;
  logic                 op_rd_q,   op_rd_d;
  logic [31:0]          wdata_q,   wdata_d;
  logic [ADDR_BITS-1:0] mar_q,     mar_d;
  logic [31:0]          mdr_q,     mdr_d;
  logic                 dropped_q, dropped_d;
  logic                 busy_q,    busy_d;
  logic                 done_q,    done_d;
  logic                 ram_we_s;
  logic [31:0]          ram_rdata_s;

  logic [31:0] ram_q [DEPTH];

  assign ram_rdata_s = ram_q[addr_q];

  // Next-state logic for the FSM, MAR/MDR registers and request capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    op_rd_d   = op_rd_q;
    wdata_d   = wdata_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    dropped_d = dropped_q;
    ram_we_s  = 1'b0;

    // MAR loads regardless of the FSM; upper bus bits are dropped so addresses wrap.
    if (MARin) begin
      mar_d = BusMuxOut[ADDR_BITS-1:0];
    end else begin
      mar_d = mar_q;
    end

    if (MDRin && !MD_read) begin
      mdr_d = BusMuxOut;
    end else begin
      mdr_d = mdr_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Read || Write) begin
          // Capture the pre-edge MAR/MDR so same-edge loads do not leak in.
          addr_d  = mar_q;
          op_rd_d = Read;
          wdata_d = mdr_q;
          cnt_d   = WAIT_INIT;
          state_d = ST_WAIT;
          if (Read && Write) begin
            dropped_d = 1'b1;
          end else begin
            dropped_d = dropped_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (Read || Write) begin
          dropped_d = 1'b1;
        end else begin
          dropped_d = dropped_q;
        end
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_DONE;
          if (op_rd_q) begin
            // Read data overrides any bus load on the same edge.
            mdr_d = ram_rdata_s;
          end else begin
            ram_we_s = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy/mem_done are registered decodes of the next state.
    busy_d = (state_d == ST_WAIT);
    done_d = (state_d == ST_DONE);
  end

  // Control and data registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      op_rd_q   <= 1'b0;
      wdata_q   <= 32'd0;
      mar_q     <= '0;
      mdr_q     <= 32'd0;
      dropped_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      op_rd_q   <= op_rd_d;
      wdata_q   <= wdata_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      dropped_q <= dropped_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // RAM write port; reset aborts a pending write and never clears contents.
  always_ff @(posedge clock) begin
    if (ram_we_s && !reset) begin
      ram_q[addr_q] <= wdata_q;
    end
  end

  assign MDR_bus     = mdr_q;
  assign MAR_out     = mar_q;
  assign busy        = busy_q;
  assign mem_done    = done_q;
  assign req_dropped = dropped_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder (WAIT_STATES=2 main instance, plus a
// WAIT_STATES=0 instance for the zero-wait latency case).
module tb_mem_responder;

  logic        clock;
  logic        reset;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, MD_read, Read, Write;
  logic [31:0] MDR_bus;
  logic [8:0]  MAR_out;
  logic        busy, mem_done, req_dropped;

  logic [31:0] z_bus;
  logic        z_marin, z_mdrin, z_md_read, z_read, z_write;
  logic [31:0] z_mdr;
  logic [8:0]  z_mar;
  logic        z_busy, z_done, z_dropped;

  int checks = 0;
  int errors = 0;

  mem_responder #(.ADDR_BITS(9), .WAIT_STATES(2)) dut (
    .clock(clock), .reset(reset), .BusMuxOut(BusMuxOut),
    .MARin(MARin), .MDRin(MDRin), .MD_read(MD_read),
    .Read(Read), .Write(Write),
    .MDR_bus(MDR_bus), .MAR_out(MAR_out), .busy(busy),
    .mem_done(mem_done), .req_dropped(req_dropped)
  );

  mem_responder #(.ADDR_BITS(9), .WAIT_STATES(0)) dut0 (
    .clock(clock), .reset(reset), .BusMuxOut(z_bus),
    .MARin(z_marin), .MDRin(z_mdrin), .MD_read(z_md_read),
    .Read(z_read), .Write(z_write),
    .MDR_bus(z_mdr), .MAR_out(z_mar), .busy(z_busy),
    .mem_done(z_done), .req_dropped(z_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic load_mar(input logic [31:0] a);
    MARin = 1'b1; BusMuxOut = a;
    cycle();
    MARin = 1'b0;
  endtask

  task automatic load_mdr(input logic [31:0] d);
    MDRin = 1'b1; MD_read = 1'b0; BusMuxOut = d;
    cycle();
    MDRin = 1'b0;
  endtask

  // Issue a request for one edge; return edges from request to mem_done (99 = timeout).
  task automatic do_req(input logic rd, input logic wr, output int lat);
    Read = rd; Write = wr;
    cycle();
    Read = 1'b0; Write = 1'b0;
    lat = 99;
    for (int i = 0; i < 20; i++) begin
      if (mem_done) begin
        lat = i;
        break;
      end
      cycle();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++; if (MDR_bus !== 32'd0) begin errors++; $display("FAIL reset_mdr: got %h expected 00000000", MDR_bus); end
    checks++; if (MAR_out !== 9'd0) begin errors++; $display("FAIL reset_mar: got %h expected 000", MAR_out); end
    checks++; if ({busy, mem_done, req_dropped} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, mem_done, req_dropped}); end
  endtask

  task automatic test_write_read();
    int lat;
    load_mar(32'h0000_0005);
    load_mdr(32'hDEAD_BEEF);
    Write = 1'b1;
    cycle();
    Write = 1'b0;
    checks++; if ({busy, mem_done} !== 2'b10) begin errors++; $display("FAIL wr_busy_after_req: got %b expected 10", {busy, mem_done}); end
    lat = 99;
    for (int i = 0; i < 20; i++) begin
      if (mem_done) begin lat = i; break; end
      cycle();
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    cycle();
    checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL wr_done_one_cycle: got %b expected 0", mem_done); end
    load_mdr(32'h0);
    checks++; if (MDR_bus !== 32'h0) begin errors++; $display("FAIL mdr_bus_load: got %h expected 00000000", MDR_bus); end
    do_req(1'b1, 1'b0, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    checks++; if (MDR_bus !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", MDR_bus); end
    checks++; if (req_dropped !== 1'b0) begin errors++; $display("FAIL wr_rd_dropped: got %b expected 0", req_dropped); end
  endtask

  task automatic test_wrap();
    int lat;
    load_mdr(32'h0);
    load_mar(32'h0000_0205);
    checks++; if (MAR_out !== 9'h005) begin errors++; $display("FAIL wrap_mar: got %h expected 005", MAR_out); end
    do_req(1'b1, 1'b0, lat);
    checks++; if (MDR_bus !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wrap_data: got %h expected deadbeef", MDR_bus); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int lat2;
    load_mar(32'h30);
    load_mdr(32'h0BAD_CAFE);
    do_req(1'b0, 1'b1, lat);
    load_mar(32'h5);
    // Read 0x005, moving MAR to 0x030 while the read is in flight.
    Read = 1'b1;
    cycle();
    Read = 1'b0;
    MARin = 1'b1; BusMuxOut = 32'h30;
    cycle();
    MARin = 1'b0;
    lat = 99;
    for (int i = 1; i < 20; i++) begin
      if (mem_done) begin lat = i; break; end
      cycle();
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 3", lat); end
    checks++; if (MDR_bus !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_first_data: got %h expected deadbeef", MDR_bus); end
    // Still in the DONE cycle: issue the next read immediately.
    do_req(1'b1, 1'b0, lat2);
    checks++; if (lat2 !== 3) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 3", lat2); end
    checks++; if (MDR_bus !== 32'h0BAD_CAFE) begin errors++; $display("FAIL b2b_second_data: got %h expected 0badcafe", MDR_bus); end
    checks++; if (req_dropped !== 1'b0) begin errors++; $display("FAIL b2b_dropped: got %b expected 0", req_dropped); end
  endtask

  task automatic test_collisions();
    int lat;
    pulse_reset();
    load_mar(32'h5);
    load_mdr(32'h1234_5678);
    Read = 1'b1;
    cycle();
    Read = 1'b0;
    Write = 1'b1;
    cycle();
    Write = 1'b0;
    lat = 99;
    for (int i = 1; i < 20; i++) begin
      if (mem_done) begin lat = i; break; end
      cycle();
    end
    checks++; if (MDR_bus !== 32'hDEAD_BEEF) begin errors++; $display("FAIL busy_write_read_data: got %h expected deadbeef", MDR_bus); end
    checks++; if (req_dropped !== 1'b1) begin errors++; $display("FAIL busy_write_dropped: got %b expected 1", req_dropped); end
    load_mdr(32'h0);
    do_req(1'b1, 1'b0, lat);
    checks++; if (MDR_bus !== 32'hDEAD_BEEF) begin errors++; $display("FAIL busy_write_ram_kept: got %h expected deadbeef", MDR_bus); end

    pulse_reset();
    load_mar(32'h30);
    load_mdr(32'h0);
    do_req(1'b1, 1'b1, lat);
    checks++; if (MDR_bus !== 32'h0BAD_CAFE) begin errors++; $display("FAIL both_read_served: got %h expected 0badcafe", MDR_bus); end
    checks++; if (req_dropped !== 1'b1) begin errors++; $display("FAIL both_dropped: got %b expected 1", req_dropped); end
    load_mdr(32'h0);
    do_req(1'b1, 1'b0, lat);
    checks++; if (MDR_bus !== 32'h0BAD_CAFE) begin errors++; $display("FAIL both_write_ignored: got %h expected 0badcafe", MDR_bus); end
  endtask

  task automatic test_wdata_capture();
    int lat;
    load_mar(32'h10);
    load_mdr(32'h1111_1111);
    Write = 1'b1;
    cycle();
    Write = 1'b0;
    MDRin = 1'b1; MD_read = 1'b0; BusMuxOut = 32'h2222_2222;
    cycle();
    MDRin = 1'b0;
    lat = 99;
    for (int i = 1; i < 20; i++) begin
      if (mem_done) begin lat = i; break; end
      cycle();
    end
    checks++; if (MDR_bus !== 32'h2222_2222) begin errors++; $display("FAIL capture_busy_load: got %h expected 22222222", MDR_bus); end
    load_mdr(32'h0);
    do_req(1'b1, 1'b0, lat);
    checks++; if (MDR_bus !== 32'h1111_1111) begin errors++; $display("FAIL capture_wdata: got %h expected 11111111", MDR_bus); end
  endtask

  task automatic test_reset_mid_write();
    int lat;
    int pulses;
    load_mar(32'h20);
    load_mdr(32'hA5A5_A5A5);
    do_req(1'b0, 1'b1, lat);
    load_mdr(32'h5A5A_5A5A);
    Write = 1'b1;
    cycle();
    Write = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++; if ({busy, mem_done} !== 2'b00) begin errors++; $display("FAIL midrst_flags: got %b expected 00", {busy, mem_done}); end
    checks++; if (MDR_bus !== 32'h0) begin errors++; $display("FAIL midrst_mdr: got %h expected 00000000", MDR_bus); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (mem_done) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", pulses); end
    load_mar(32'h20);
    do_req(1'b1, 1'b0, lat);
    checks++; if (MDR_bus !== 32'hA5A5_A5A5) begin errors++; $display("FAIL midrst_ram_kept: got %h expected a5a5a5a5", MDR_bus); end
  endtask

  task automatic test_zero_wait();
    z_marin = 1'b1; z_bus = 32'h3;
    cycle();
    z_marin = 1'b0; z_mdrin = 1'b1; z_md_read = 1'b0; z_bus = 32'h77;
    cycle();
    z_mdrin = 1'b0; z_write = 1'b1;
    cycle();
    z_write = 1'b0;
    checks++; if ({z_busy, z_done} !== 2'b10) begin errors++; $display("FAIL zw_write_wait: got %b expected 10", {z_busy, z_done}); end
    cycle();
    checks++; if ({z_busy, z_done} !== 2'b01) begin errors++; $display("FAIL zw_write_done: got %b expected 01", {z_busy, z_done}); end
    z_mdrin = 1'b1; z_bus = 32'h0;
    cycle();
    z_mdrin = 1'b0; z_read = 1'b1;
    cycle();
    z_read = 1'b0;
    cycle();
    checks++; if (z_done !== 1'b1) begin errors++; $display("FAIL zw_read_done: got %b expected 1", z_done); end
    checks++; if (z_mdr !== 32'h77) begin errors++; $display("FAIL zw_read_data: got %h expected 00000077", z_mdr); end
  endtask

  initial begin
    reset = 1'b1; BusMuxOut = 32'h0;
    MARin = 1'b0; MDRin = 1'b0; MD_read = 1'b0; Read = 1'b0; Write = 1'b0;
    z_bus = 32'h0; z_marin = 1'b0; z_mdrin = 1'b0; z_md_read = 1'b0;
    z_read = 1'b0; z_write = 1'b0;
    cycle();
    test_reset();
    test_write_read();
    test_wrap();
    test_back_to_back();
    test_collisions();
    test_wdata_capture();
    test_reset_mid_write();
    test_zero_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
